// File: rtl/countdown_timer_4b.sv
// 4-bit down-counting timer with a prescaled count step, pause/resume and
// optional auto-reload from a preset captured on load.
module countdown_timer_4b #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       start,
  input  logic       pause,
  input  logic       auto_reload,
  output logic [3:0] Q,
  output logic       tick,
  output logic       done,
  output logic       busy
);

  // state | meaning
  // IDLE  | loaded or reset, waiting for start
  // RUN   | prescaler advancing, Q steps down on each wrap
  // PAUSE | prescaler and Q frozen, waiting for start
  // DONE  | terminal count reached, Q held at 0
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        state;
  logic [3:0]    preset;
  logic [PW-1:0] presc;
  logic          step;

  // Count-step enable: the prescaler is about to wrap while running.
  assign step = (state == RUN) && (presc == PRESC_MAX);
  assign busy = (state == RUN) || (state == PAUSE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      Q      <= 4'd0;
      preset <= 4'd0;
      presc  <= '0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (load) begin
        Q      <= din;
        preset <= din;
        presc  <= '0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (start) begin
              if (Q != 4'd0) begin
                state <= RUN;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          RUN: begin
            presc <= step ? '0 : presc + 1'b1;
            // A step on the same edge as pause still takes effect before pausing.
            if (step) begin
              tick <= 1'b1;
              if (Q == 4'd1) begin
                done <= 1'b1;
                if (auto_reload && (preset != 4'd0)) begin
                  Q     <= preset;
                  state <= pause ? PAUSE : RUN;
                end else begin
                  Q     <= 4'd0;
                  state <= DONE;
                end
              end else begin
                Q     <= Q - 4'd1;
                state <= pause ? PAUSE : RUN;
              end
            end else if (pause) begin
              state <= PAUSE;
            end
          end
          PAUSE: begin
            if (start) state <= RUN;
          end
          DONE: begin
            presc <= '0;
            Q     <= 4'd0;
            if (start) begin
              if (preset != 4'd0) begin
                Q     <= preset;
                state <= RUN;
              end else begin
                done <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_4b.sv
// Scoreboard bench for countdown_timer_4b: directed scenarios plus random
// strobes, checked every cycle against a remaining-cycles reference model.
module tb_countdown_timer_4b;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] Q;
  logic       tick, done, busy;

  countdown_timer_4b #(.TICK_DIV(N)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din), .start(start),
    .pause(pause), .auto_reload(auto_reload), .Q(Q), .tick(tick),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit tk;
    bit dn;
    bit bz;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc_no = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused, 3 finished;
  // m_left counts the clock edges still to go before the next count step.
  int m_mode = 0, m_q = 0, m_pre = 0, m_left = N;
  bit m_tk = 0, m_dn = 0;

  function automatic void model_reset();
    m_mode = 0; m_q = 0; m_pre = 0; m_left = N; m_tk = 0; m_dn = 0;
  endfunction

  function automatic void model_edge(bit l, int d, bit s, bit p, bit ar);
    m_tk = 0;
    m_dn = 0;
    if (l) begin
      m_q = d; m_pre = d; m_mode = 0; m_left = N;
    end else if (m_mode == 0) begin
      if (s) begin
        if (m_q != 0) begin m_mode = 1; m_left = N; end
        else begin m_mode = 3; m_dn = 1; end
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left = N;
        m_tk = 1;
        if (m_q == 1) begin
          m_dn = 1;
          if (ar && m_pre != 0) m_q = m_pre;
          else begin m_q = 0; m_mode = 3; end
        end else begin
          m_q = m_q - 1;
        end
      end
      if (p && m_mode == 1) m_mode = 2;
    end else if (m_mode == 2) begin
      if (s) m_mode = 1;
    end else begin
      if (s) begin
        if (m_pre != 0) begin m_q = m_pre; m_mode = 1; m_left = N; end
        else m_dn = 1;
      end
    end
  endfunction

  // One clock edge with the given inputs; the expected result is queued.
  task automatic cyc(input bit l, input int d, input bit s, input bit p);
    exp_t e;
    load = l; din = 4'(d); start = s; pause = p;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_edge(l, d, s, p, auto_reload);
    cyc_no++;
    e.q = m_q; e.tk = m_tk; e.dn = m_dn;
    e.bz = (m_mode == 1 || m_mode == 2); e.cyc = cyc_no;
    exp_q.push_back(e);
    load = 0; start = 0; pause = 0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_chk++;
    if (Q !== 4'd0 || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got Q=%0d tick=%b done=%b busy=%b, want all 0",
               Q, tick, done, busy);
    end
    model_reset();
    idle_n(2);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (Q !== 4'(e.q) || tick !== e.tk || done !== e.dn || busy !== e.bz) begin
        n_fail++;
        $display("FAIL cycle_%0d: got Q=%0d tick=%b done=%b busy=%b, want Q=%0d tick=%b done=%b busy=%b",
                 e.cyc, Q, tick, done, busy, e.q, e.tk, e.dn, e.bz);
      end
    end
  end

  initial begin
    #1;
    n_chk++;
    if (Q !== 4'd0 || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got Q=%0d tick=%b done=%b busy=%b, want all 0",
               Q, tick, done, busy);
    end
    idle_n(2);
    reset = 1'b0;

    // basic countdown from 3
    auto_reload = 0;
    cyc(1, 3, 0, 0); cyc(0, 0, 1, 0); idle_n(16);
    // pause mid-count then resume with held prescaler
    cyc(1, 5, 0, 0); cyc(0, 0, 1, 0); idle_n(5); cyc(0, 0, 0, 1);
    idle_n(4); cyc(0, 0, 0, 1); cyc(0, 0, 1, 0); idle_n(24);
    // auto reload 2,1,2,1...
    auto_reload = 1;
    cyc(1, 2, 0, 0); cyc(0, 0, 1, 0); idle_n(20);
    auto_reload = 0;
    idle_n(10);
    // zero preset: immediate done, and again from DONE
    cyc(1, 0, 0, 0); cyc(0, 0, 1, 0); idle_n(2); cyc(0, 0, 1, 1); idle_n(2);
    // load + start together mid-run, then reset mid-run
    cyc(1, 4, 0, 0); cyc(0, 0, 1, 0); idle_n(8);
    cyc(1, 9, 1, 0); idle_n(3); cyc(0, 0, 1, 0); idle_n(3);
    async_reset();
    idle_n(2);
    // pause coinciding with the terminal step
    cyc(1, 2, 0, 0); cyc(0, 0, 1, 0); idle_n(7); cyc(0, 0, 0, 1); idle_n(3);
    // start and pause together in IDLE and RUN, start in RUN
    cyc(1, 3, 0, 0); cyc(0, 0, 1, 1); idle_n(2); cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); idle_n(12);
    // reset while paused
    cyc(1, 6, 0, 0); cyc(0, 0, 1, 0); idle_n(3); cyc(0, 0, 0, 1);
    async_reset();
    cyc(0, 0, 1, 0); idle_n(2);

    // random strobes
    for (int i = 0; i < 3000; i++) begin
      bit l, s, p;
      if ($urandom_range(0, 63) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(0, 999) == 0) async_reset();
      l = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 9) == 0);
      cyc(l, int'($urandom_range(0, 15)), s, p);
    end

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer_4b.md
COUNTDOWN_TIMER_4B -- requirements
Module: countdown_timer_4b

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per count step (1 Hz at 50 MHz); SHALL be >= 2.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  synchronous load strobe, sampled each clk edge.
REQ-005 din  input  4  preset value captured on load.
REQ-006 start  input  1  start/resume strobe.
REQ-007 pause  input  1  pause strobe.
REQ-008 auto_reload  input  1  level; 1 = restart from preset at terminal count.
REQ-009 Q  output  4  current count, registered.
REQ-010 tick  output  1  one-cycle pulse per count step, registered.
REQ-011 done  output  1  one-cycle terminal-count pulse, registered.
REQ-012 busy  output  1  high in RUN or PAUSE, registered/decoded from state register only.

Function
REQ-013 Single clock domain; no derived or gated clocks; count steps SHALL use tick as a clock enable.
REQ-014 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-015 Internal 4-bit preset register SHALL hold the last din captured on load.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; tick asserts on the edge where prescaler wraps from TICK_DIV-1 to 0.
REQ-017 Prescaler SHALL hold its value in PAUSE and clear to 0 on load, on entry to RUN from IDLE or DONE, and in IDLE/DONE.
REQ-018 Priority per edge: load > start/pause > tick.
REQ-019 load in any state: Q <= din, preset <= din, state -> IDLE, done = 0, tick = 0.
REQ-020 IDLE + start: Q != 0 -> RUN; Q == 0 -> DONE with done pulse on that edge.
REQ-021 RUN + tick: Q <= Q - 1 (4-bit, no wrap below 0 reachable).
REQ-022 RUN + tick with Q == 1: done pulse; auto_reload = 0 -> Q <= 0, state DONE; auto_reload = 1 -> Q <= preset, stay RUN (preset == 0 -> Q <= 0, state DONE).
REQ-023 RUN + pause: state -> PAUSE; if tick occurs same edge, decrement/terminal action of REQ-021/022 SHALL still apply, then PAUSE (DONE if terminal without reload).
REQ-024 RUN + start: ignored.
REQ-025 PAUSE + start: state -> RUN, prescaler resumes from held value; pause in PAUSE ignored; Q frozen.
REQ-026 start and pause same edge: start wins in IDLE/PAUSE/DONE, pause wins in RUN.
REQ-027 DONE: Q holds 0; start -> Q <= preset, RUN (preset == 0 -> stay DONE, new done pulse).
REQ-028 done and tick SHALL never be high for more than one consecutive cycle each.

Reset
REQ-029 reset high: Q = 0, preset = 0, prescaler = 0, state IDLE, tick = 0, done = 0, busy = 0, immediately, independent of clk.
REQ-030 reset asserted mid-RUN or mid-PAUSE SHALL abort the count with no done pulse.
REQ-031 After reset release, first edge SHALL obey REQ-018..027 from IDLE.

Verification (TICK_DIV = 4)
REQ-032 load din=3, start -> tick every 4 cycles; Q 3,2,1,0; done single pulse with Q->0; busy drops; state DONE.
REQ-033 load 5, start, pause after 6 cycles -> Q=4 held, busy=1, no tick; start -> next tick exactly 2 cycles later (held prescaler), Q=3.
REQ-034 load 2, auto_reload=1, start -> Q 2,1,2,1,... done pulse at each 1->reload edge, busy stays 1.
REQ-035 load 0, start -> done pulse next edge, Q=0, busy=0; start again in DONE -> another done pulse.
REQ-036 RUN at Q=2, load din=9 and start same edge -> Q=9, IDLE, no tick/done; reset mid-RUN -> all outputs 0 asynchronously.
REQ-037 pause coinciding with tick at Q=1, auto_reload=0 -> Q=0, done pulse, state DONE, busy=0.
